// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Op codes, FSM states and default cycle counts.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 32x32 products and
// a single shared divider on magnitudes.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        dz
);

  logic [63:0] ps;
  logic [63:0] pu;
  logic [31:0] da;
  logic [31:0] db;
  logic [31:0] q;
  logic [31:0] r;
  logic        sdiv;

  always_comb begin
    ps   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    pu   = {32'b0, rs} * {32'b0, rt};
    sdiv = (op == OP_DIV);
    da   = (sdiv && rs[31]) ? -rs : rs;
    db   = (sdiv && rt[31]) ? -rt : rt;
    q    = '0;
    r    = '0;
    if (db != '0) begin
      q = da / db;
      r = da % db;
    end
    hi_n = '0;
    lo_n = '0;
    dz   = 1'b0;
    unique case (1'b1)
      (op == OP_MULT): {hi_n, lo_n} = ps;
      (op == OP_MULTU): {hi_n, lo_n} = pu;
      (op == OP_DIV): begin
        // quotient negates on sign mismatch, remainder follows dividend
        lo_n = (rs[31] ^ rt[31]) ? -q : q;
        hi_n = rs[31] ? -r : r;
        dz   = (rt == '0);
      end
      (op == OP_DIVU): begin
        lo_n = q;
        hi_n = r;
        dz   = (rt == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MDU sequencer: accepts mult/div, holds the
// result pending for a fixed latency, then commits HI/LO.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall,
  output logic        done
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] MLOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DLOAD = CW'(DIV_CYCLES - 1);

  state_e      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [63:0] pend, pend_n;
  logic        pdz, pdz_n;
  logic [31:0] hi_d, lo_d;
  logic        busy_n, done_n;
  logic [31:0] hi_c, lo_c;
  logic        dz;

  mdu_arith u_arith (
    .op   (op),
    .rs   (rs),
    .rt   (rt),
    .hi_n (hi_c),
    .lo_n (lo_c),
    .dz   (dz)
  );

  assign md_stall = md_use & (busy | (start & ~op[2]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= '0;
      pdz   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      pdz   <= pdz_n;
      hi    <= hi_d;
      lo    <= lo_d;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    pdz_n   = pdz;
    hi_d    = hi;
    lo_d    = lo;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !op[2]) begin
          state_n = S_RUN;
          cnt_n   = op[1] ? DLOAD : MLOAD;
          pend_n  = {hi_c, lo_c};
          pdz_n   = dz;
          busy_n  = 1'b1;
        end else if (start && op == OP_MTHI) begin
          hi_d = rs;
        end else if (start && op == OP_MTLO) begin
          lo_d = rs;
        end
      end
      S_RUN: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          // divide-by-zero leaves HI/LO as they were
          if (!pdz) {hi_d, lo_d} = pend;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed corner cases plus random ops
// against an arithmetic reference of HI/LO and timing.
module tb_mdu_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        md_use;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_stall;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .md_use   (md_use),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .md_stall (md_stall),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(
      input logic [2:0] o, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] h,
      input logic [31:0] l);
    longint sa, sb, sq, sr;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = {h, l};
    case (o)
      3'd0: res = 64'(sa * sb);
      3'd1: res = {32'b0, a} * {32'b0, b};
      3'd2: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end
      3'd3: if (b != 0) res = {a % b, a / b};
      3'd4: res = {a, l};
      3'd5: res = {h, a};
      default: ;
    endcase
    return res;
  endfunction

  task automatic do_op(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic mu,
                       input logic intrude);
    logic [63:0] exp;
    int n;
    exp = ref_md(o, a, b, m_hi, m_lo);
    start = 1'b1; op = o; rs = a; rt = b; md_use = mu;
    #1 check("stall_acc", md_stall, mu & (o <= 3));
    @(negedge clk);
    start = intrude; op = 3'd5;
    rs = $urandom; rt = $urandom;
    if (o <= 3) begin
      n = (o < 2) ? 5 : 10;
      for (int j = 0; j <= n; j++) begin
        if (j < n) begin
          check("busy_run", busy, 1'b1);
          check("done_run", done, 1'b0);
          check("hold_hilo", {hi, lo}, {m_hi, m_lo});
          check("stall_run", md_stall, mu);
          @(negedge clk);
        end else begin
          check("busy_end", busy, 1'b0);
          check("done_end", done, 1'b1);
          check("commit", {hi, lo}, exp);
        end
      end
      start = 1'b0; md_use = 1'b0;
      @(negedge clk);
      check("done_pulse", done, 1'b0);
    end else begin
      start = 1'b0; md_use = 1'b0;
      check("mt_hilo", {hi, lo}, exp);
      check("mt_busy", busy, 1'b0);
      check("mt_done", done, 1'b0);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  initial begin
    logic [2:0] o;
    logic [31:0] a, b;
    reset_n = 1'b0; start = 1'b0; op = '0;
    rs = '0; rt = '0; md_use = 1'b0;
    #12;
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check("mult_dir", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("div_dir", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("divu_dir", {hi, lo}, 64'h00000001_7FFFFFFC);
    do_op(3'd4, 32'h11, 32'd0, 1'b0, 1'b0);
    do_op(3'd5, 32'h22, 32'd0, 1'b0, 1'b0);
    do_op(3'd3, 32'h1234, 32'd0, 1'b0, 1'b0);
    check("divz_dir", {hi, lo}, 64'h00000011_00000022);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("div_ovf", {hi, lo}, 64'h00000000_80000000);
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b1, 1'b1);
    check("mult_intr", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    do_op(3'd4, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    check("mthi_dir", hi, 32'hDEADBEEF);
    do_op(3'd7, 32'h5555, 32'h1, 1'b0, 1'b0);

    start = 1'b1; op = 3'd2; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_hilo", {hi, lo}, 64'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("post_rst_done", done, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end
    check("post_rst_hilo", {hi, lo}, 64'h0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      do_op(o, a, b, 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
